// File: rtl/card_pkg.sv
// =====================================================================
// card_pkg : shared types and defaults for the round-robin merger. rev 1.0
// =====================================================================
`default_nettype none

package card_pkg;

    localparam int CARD_N_PORTS   = 8;
    localparam int CARD_DATA_W    = 64;
    localparam int CARD_BURST_MAX = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } card_state_e;

    function automatic int card_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/card_rr_pick.sv
// =====================================================================
// card_rr_pick : rotating-priority picker, search starts after last_i. rev 1.0
// =====================================================================
`default_nettype none

module card_rr_pick
    import card_pkg::*;
#(
    parameter int   N_PORTS = CARD_N_PORTS,
    localparam int  IDX_W   = card_idx_w(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    int p_idx;

    // Walk from farthest to nearest so the nearest requester wins last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        p_idx   = 0;
        for (int k = N_PORTS; k >= 1; k--) begin
            p_idx = (int'(last_i) + k) % N_PORTS;
            if (req_i[p_idx]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(p_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/card_rr_merge.sv
// =====================================================================
// card_rr_merge : merges N streams into one, round-robin bursts. rev 1.0
// =====================================================================
`default_nettype none

module card_rr_merge
    import card_pkg::*;
#(
    parameter int N_PORTS    = CARD_N_PORTS,
    parameter int DATA_WIDTH = CARD_DATA_W,
    parameter int BURST_MAX  = CARD_BURST_MAX
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [N_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [N_PORTS-1:0]            s_tvalid,
    output logic [N_PORTS-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [31:0]                   beat_count
);

    localparam int                IDX_W    = card_idx_w(N_PORTS);
    localparam int                BCNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_PORTS - 1);
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BURST_MAX);

    card_state_e           state_q, state_d;
    logic [IDX_W-1:0]      gnt_q, gnt_d;
    logic [IDX_W-1:0]      last_gnt_q, last_gnt_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic [31:0]           beat_count_q, beat_count_d;

    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic                  out_ready;
    logic                  gnt_valid;
    logic                  in_xfer;
    logic [DATA_WIDTH-1:0] gnt_data;

    card_rr_pick #(
        .N_PORTS (N_PORTS)
    ) u_pick (
        .req_i   (s_tvalid),
        .last_i  (last_gnt_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign out_ready = !m_tvalid_q || m_tready;
    assign gnt_valid = s_tvalid[gnt_q];
    assign gnt_data  = s_tdata[gnt_q*DATA_WIDTH +: DATA_WIDTH];
    // Reset gates acceptance so nothing is taken from upstream in the reset cycle.
    assign in_xfer   = (state_q == HOLD) && gnt_valid && out_ready && !areset;

    always_comb begin
        s_tready = '0;
        if ((state_q == HOLD) && out_ready && !areset) begin
            s_tready[gnt_q] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        bcnt_d     = bcnt_q;
        last_gnt_d = last_gnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    bcnt_d  = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Downstream stalls neither advance bcnt nor release the grant.
                if (in_xfer) begin
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_d == BCNT_MAX) begin
                        state_d    = IDLE;
                        last_gnt_d = gnt_q;
                    end
                end else if (!gnt_valid) begin
                    state_d    = IDLE;
                    last_gnt_d = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        beat_count_d = beat_count_q;
        if (m_tvalid_q && m_tready) begin
            beat_count_d = beat_count_q + 32'd1;
        end
        if (in_xfer) begin
            m_tdata_d  = gnt_data;
            m_tvalid_d = 1'b1;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            bcnt_q       <= '0;
            last_gnt_q   <= LAST_RST;
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            bcnt_q       <= bcnt_d;
            last_gnt_q   <= last_gnt_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign m_tdata    = m_tdata_q;
    assign m_tvalid   = m_tvalid_q;
    assign beat_count = beat_count_q;

endmodule

`default_nettype wire

// File: tb/tb_card_rr_merge.sv
// =====================================================================
// tb_card_rr_merge : randomized scenario bench with round-robin reference model. rev 1.0
// =====================================================================
`default_nettype none

module tb_card_rr_merge;

    localparam int NP = 8;
    localparam int DW = 64;
    localparam int BM = 16;

    logic              aclk = 1'b0;
    logic              areset;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [31:0]       beat_count;

    card_rr_merge #(
        .N_PORTS    (NP),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .beat_count (beat_count)
    );

    always #5 aclk = ~aclk;

    // Source queues (consumed by handshakes) and pristine model copies.
    logic [DW-1:0] src_q [NP][$];
    logic [DW-1:0] mdl_q [NP][$];
    bit            valid_en [NP];
    int            sent_cnt [NP];
    int            drop_at  [NP];
    int            rdy_mode;
    int            cyc;

    logic [DW-1:0] obs_d [$];
    int            obs_c [$];
    logic [DW-1:0] exp_d [$];
    bit            exp_first [$];

    logic [NP-1:0] tr_sr [$];
    logic          tr_mv [$];
    logic          tr_mr [$];
    logic [DW-1:0] tr_md [$];
    logic [31:0]   tr_bc [$];

    int n_chk;
    int n_pass;

    task automatic cycle();
        logic [NP-1:0] hs;
        for (int p = 0; p < NP; p++) begin
            s_tvalid[p] = valid_en[p] && (src_q[p].size() > 0);
            if (src_q[p].size() > 0) s_tdata[p*DW +: DW] = src_q[p][0];
            else                     s_tdata[p*DW +: DW] = '0;
        end
        m_tready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
        @(negedge aclk);
        hs = s_tvalid & s_tready;
        tr_sr.push_back(s_tready);
        tr_mv.push_back(m_tvalid);
        tr_mr.push_back(m_tready);
        tr_md.push_back(m_tdata);
        tr_bc.push_back(beat_count);
        if (!areset && m_tvalid && m_tready) begin
            obs_d.push_back(m_tdata);
            obs_c.push_back(cyc);
        end
        @(posedge aclk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                void'(src_q[p].pop_front());
                sent_cnt[p]++;
                if (sent_cnt[p] == drop_at[p]) valid_en[p] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic clear_tb();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            mdl_q[p].delete();
            valid_en[p] = 1'b0;
            sent_cnt[p] = 0;
            drop_at[p]  = -1;
        end
        obs_d.delete(); obs_c.delete(); exp_d.delete(); exp_first.delete();
        tr_sr.delete(); tr_mv.delete(); tr_mr.delete(); tr_md.delete(); tr_bc.delete();
        rdy_mode = 0;
    endtask

    task automatic do_reset();
        clear_tb();
        areset = 1'b1;
        repeat (2) cycle();
        areset = 1'b0;
        obs_d.delete(); obs_c.delete();
        tr_sr.delete(); tr_mv.delete(); tr_mr.delete(); tr_md.delete(); tr_bc.delete();
    endtask

    task automatic load(input int p, input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            src_q[p].push_back(w);
            mdl_q[p].push_back(w);
        end
    endtask

    task automatic run_until(input int n_out, input int budget);
        for (int i = 0; i < budget && obs_d.size() < n_out; i++) cycle();
    endtask

    // Reference: continuously-valid ports served round robin from port 0,
    // at most BM words per grant, one idle input cycle per grant switch.
    task automatic model_rr();
        int  last;
        int  p;
        int  take;
        bit  any;
        exp_d.delete();
        exp_first.delete();
        last = NP - 1;
        forever begin
            any = 1'b0;
            p   = 0;
            for (int k = 1; k <= NP && !any; k++) begin
                p = (last + k) % NP;
                if (mdl_q[p].size() > 0) any = 1'b1;
            end
            if (!any) break;
            take = (mdl_q[p].size() < BM) ? mdl_q[p].size() : BM;
            for (int i = 0; i < take; i++) begin
                exp_first.push_back((i == 0) && (exp_d.size() > 0));
                exp_d.push_back(mdl_q[p].pop_front());
            end
            last = p;
        end
    endtask

    task automatic test_reset();
        clear_tb();
        for (int p = 0; p < NP; p++) begin
            load(p, 4);
            valid_en[p] = 1'b1;
        end
        areset = 1'b1;
        repeat (3) cycle();
        n_chk++;
        if (tr_sr[tr_sr.size()-1] !== '0) $display("FAIL reset_s_tready: got %b expected %b", tr_sr[tr_sr.size()-1], 8'h00);
        else n_pass++;
        n_chk++;
        if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid);
        else n_pass++;
        n_chk++;
        if (m_tdata !== '0) $display("FAIL reset_m_tdata: got %h expected 0", m_tdata);
        else n_pass++;
        n_chk++;
        if (beat_count !== 32'd0) $display("FAIL reset_beat_count: got %0d expected 0", beat_count);
        else n_pass++;
        areset = 1'b0;
        cycle();
        n_chk++;
        if (tr_sr[tr_sr.size()-1] !== 8'h00) $display("FAIL first_cycle_ready: got %b expected %b", tr_sr[tr_sr.size()-1], 8'h00);
        else n_pass++;
        cycle();
        n_chk++;
        if (tr_sr[tr_sr.size()-1] !== 8'h01) $display("FAIL first_grant_port0: got %b expected %b", tr_sr[tr_sr.size()-1], 8'h01);
        else n_pass++;
    endtask

    task automatic test_all_ports();
        int bad;
        do_reset();
        for (int p = 0; p < NP; p++) begin
            load(p, (p == 0) ? 2*BM : BM);
            valid_en[p] = 1'b1;
        end
        model_rr();
        run_until(exp_d.size(), 400);
        n_chk++;
        if (obs_d.size() !== exp_d.size()) $display("FAIL all_ports_count: got %0d expected %0d", obs_d.size(), exp_d.size());
        else n_pass++;
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_chk++;
            if (obs_d[i] !== exp_d[i]) $display("FAIL all_ports_word %0d: got %h expected %h", i, obs_d[i], exp_d[i]);
            else n_pass++;
        end
        for (int i = 1; i < obs_c.size() && i < exp_first.size(); i++) begin
            n_chk++;
            if ((obs_c[i] - obs_c[i-1]) !== (exp_first[i] ? 2 : 1))
                $display("FAIL all_ports_spacing %0d: got %0d expected %0d", i, obs_c[i] - obs_c[i-1], exp_first[i] ? 2 : 1);
            else n_pass++;
        end
        bad = 0;
        foreach (tr_sr[t]) if ($countones(tr_sr[t]) > 1) bad++;
        n_chk++;
        if (bad !== 0) $display("FAIL all_ports_onehot_ready: got %0d multi-hot cycles expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_single_port();
        do_reset();
        load(3, 40);
        valid_en[3] = 1'b1;
        model_rr();
        run_until(exp_d.size(), 200);
        repeat (2) cycle();
        n_chk++;
        if (obs_d.size() !== 40) $display("FAIL single_port_count: got %0d expected 40", obs_d.size());
        else n_pass++;
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_chk++;
            if (obs_d[i] !== exp_d[i]) $display("FAIL single_port_word %0d: got %h expected %h", i, obs_d[i], exp_d[i]);
            else n_pass++;
        end
        for (int i = 1; i < obs_c.size() && i < exp_first.size(); i++) begin
            n_chk++;
            if ((obs_c[i] - obs_c[i-1]) !== (exp_first[i] ? 2 : 1))
                $display("FAIL single_port_spacing %0d: got %0d expected %0d", i, obs_c[i] - obs_c[i-1], exp_first[i] ? 2 : 1);
            else n_pass++;
        end
        n_chk++;
        if (beat_count !== 32'd40) $display("FAIL single_port_beat_count: got %0d expected 40", beat_count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        rdy_mode = 1;
        load(2, BM);
        load(5, BM);
        valid_en[2] = 1'b1;
        valid_en[5] = 1'b1;
        model_rr();
        run_until(exp_d.size(), 300);
        n_chk++;
        if (obs_d.size() !== 2*BM) $display("FAIL backpressure_count: got %0d expected %0d", obs_d.size(), 2*BM);
        else n_pass++;
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_chk++;
            if (obs_d[i] !== exp_d[i]) $display("FAIL backpressure_word %0d: got %h expected %h", i, obs_d[i], exp_d[i]);
            else n_pass++;
        end
        bad = 0;
        for (int t = 1; t < tr_mv.size(); t++) begin
            if (tr_mv[t-1] && !tr_mr[t-1] && (!tr_mv[t] || (tr_md[t] !== tr_md[t-1]))) bad++;
        end
        n_chk++;
        if (bad !== 0) $display("FAIL backpressure_stable: got %0d unstable stalls expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_drop_valid();
        do_reset();
        load(6, 10);
        drop_at[6]  = 5;
        valid_en[6] = 1'b1;
        for (int i = 0; i < 20 && sent_cnt[6] < 1; i++) cycle();
        load(1, 8);
        valid_en[1] = 1'b1;
        for (int i = 0; i < 5; i++) exp_d.push_back(mdl_q[6][i]);
        for (int i = 0; i < 8; i++) exp_d.push_back(mdl_q[1][i]);
        run_until(exp_d.size(), 100);
        repeat (3) cycle();
        n_chk++;
        if (obs_d.size() !== 13) $display("FAIL drop_valid_count: got %0d expected 13", obs_d.size());
        else n_pass++;
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_chk++;
            if (obs_d[i] !== exp_d[i]) $display("FAIL drop_valid_word %0d: got %h expected %h", i, obs_d[i], exp_d[i]);
            else n_pass++;
        end
        n_chk++;
        if (sent_cnt[6] !== 5) $display("FAIL drop_valid_port6_taken: got %0d expected 5", sent_cnt[6]);
        else n_pass++;
    endtask

    task automatic test_reset_midburst();
        do_reset();
        load(4, 30);
        valid_en[4] = 1'b1;
        for (int i = 0; i < 100 && sent_cnt[4] < 6; i++) cycle();
        n_chk++;
        if (sent_cnt[4] !== 6) $display("FAIL midburst_reach: got %0d words expected 6", sent_cnt[4]);
        else n_pass++;
        areset = 1'b1;
        load(0, 20);
        valid_en[0] = 1'b1;
        cycle();
        n_chk++;
        if (tr_sr[tr_sr.size()-1] !== 8'h00) $display("FAIL midburst_reset_ready: got %b expected %b", tr_sr[tr_sr.size()-1], 8'h00);
        else n_pass++;
        areset = 1'b0;
        obs_d.delete();
        obs_c.delete();
        cycle();
        n_chk++;
        if (tr_mv[tr_mv.size()-1] !== 1'b0) $display("FAIL midburst_m_tvalid: got %b expected 0", tr_mv[tr_mv.size()-1]);
        else n_pass++;
        n_chk++;
        if (tr_bc[tr_bc.size()-1] !== 32'd0) $display("FAIL midburst_beat_count: got %0d expected 0", tr_bc[tr_bc.size()-1]);
        else n_pass++;
        for (int i = 0; i < BM; i++) exp_d.push_back(mdl_q[0][i]);
        for (int i = 0; i < BM; i++) exp_d.push_back(mdl_q[4][6+i]);
        run_until(exp_d.size(), 200);
        n_chk++;
        if (obs_d.size() < exp_d.size()) $display("FAIL midburst_count: got %0d expected %0d", obs_d.size(), exp_d.size());
        else n_pass++;
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            n_chk++;
            if (obs_d[i] !== exp_d[i]) $display("FAIL midburst_word %0d: got %h expected %h", i, obs_d[i], exp_d[i]);
            else n_pass++;
        end
    endtask

    task automatic test_beat_wrap();
        do_reset();
        force dut.beat_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.beat_count_q;
        n_chk++;
        if (beat_count !== 32'hFFFF_FFFF) $display("FAIL wrap_preload: got %h expected %h", beat_count, 32'hFFFF_FFFF);
        else n_pass++;
        load(0, 1);
        valid_en[0] = 1'b1;
        run_until(1, 20);
        n_chk++;
        if (obs_d.size() !== 1) $display("FAIL wrap_handshake: got %0d expected 1", obs_d.size());
        else n_pass++;
        n_chk++;
        if (beat_count !== 32'd0) $display("FAIL wrap_beat_count: got %h expected %h", beat_count, 32'd0);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        cyc      = 0;
        areset   = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
        clear_tb();
        #1;
        test_reset();
        test_all_ports();
        test_single_port();
        test_backpressure();
        test_drop_valid();
        test_reset_midburst();
        test_beat_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
